// File: rtl/csa_seq_ctrl.sv
// Sequenced WIDTH-bit adder: one 4-bit carry-skip slice is iterated LSB nibble first,
// with a registered carry between passes and a count of slices that took the skip path.

module csa_skip4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c,
  output logic       o_skip
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic       w_ripple;

  assign w_p    = i_a ^ i_b;
  assign w_g    = i_a & i_b;
  assign o_skip = &w_p;

  always_comb begin
    o_s      = '0;
    w_ripple = i_c;
    for (int unsigned i = 0; i < 4; i++) begin
      o_s[i]   = w_p[i] ^ w_ripple;
      w_ripple = w_g[i] | (w_p[i] & w_ripple);
    end
  end

  // With every propagate bit set the ripple carry equals i_c, so bypassing it is exact.
  assign o_c = o_skip ? i_c : w_ripple;

endmodule

module csa_seq_ctrl #(
  parameter  int unsigned WIDTH  = 16,
  localparam int unsigned NSLICE = WIDTH / 4,
  localparam int unsigned CW     = $clog2(NSLICE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic [CW-1:0]    skip_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(NSLICE - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_idx;
  logic [CW-1:0]    r_skip_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_c_out;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_sum;
  logic             w_carry;
  logic             w_skip;

  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (r_idx == CW'(i)) begin
        w_a_nib = r_a[4*i +: 4];
        w_b_nib = r_b[4*i +: 4];
      end
    end
  end

  csa_skip4 u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_c    (r_carry),
    .o_s    (w_sum),
    .o_c    (w_carry),
    .o_skip (w_skip)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_skip_cnt <= '0;
      r_s        <= '0;
      r_c_out    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= c_in;
            r_idx      <= '0;
            r_skip_cnt <= '0;
            r_s        <= '0;
            r_c_out    <= 1'b0;
            r_state    <= S_RUN;
          end else begin
            r_state    <= S_IDLE;
          end
        end
        S_RUN: begin
          // Constant-index write per nibble keeps every part-select in range.
          for (int unsigned i = 0; i < NSLICE; i++) begin
            if (r_idx == CW'(i)) begin
              r_s[4*i +: 4] <= w_sum;
            end
          end
          r_carry    <= w_carry;
          r_skip_cnt <= r_skip_cnt + CW'(w_skip);
          r_idx      <= r_idx + CW'(1);
          if (r_idx == LAST_IDX) begin
            r_c_out <= w_carry;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign s        = r_s;
  assign c_out    = r_c_out;
  assign skip_cnt = r_skip_cnt;

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Directed-vector and corner-sequence bench for csa_seq_ctrl at WIDTH=16.

module tb_csa_seq_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CW    = 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic [CW-1:0]    skip_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  csa_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .s        (s),
    .c_out    (c_out),
    .skip_cnt (skip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic [2:0]  sk;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] mskip(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p;
    logic [3:0]  nib;
    mskip = '0;
    p = x ^ y;
    for (int i = 0; i < 4; i++) begin
      nib = p[4*i +: 4];
      if (nib == 4'hF) mskip = mskip + 3'd1;
    end
  endfunction

  // Called at #1 after an edge with the DUT idle; ends at #1 after the IDLE edge that follows done.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                        input logic [15:0] es, input logic ec, input logic [2:0] ek,
                        input bit mid, input string tag);
    int lat;
    int nbusy;
    bit got;
    logic [15:0] held;
    a = ta; b = tbv; c_in = tc; start = 1'b1;
    lat = 0; nbusy = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        if (mid) begin
          start = 1'b1; a = 16'hAAAA; b = 16'h5555; c_in = 1'b1;
        end else begin
          start = 1'b0;
        end
      end else if (lat == 2) begin
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
      end
      if (busy) nbusy++;
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_latency"}, 32'(lat), 32'd5);
      chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd4);
      chk({tag, "_s"}, 32'(s), 32'(es));
      chk({tag, "_c_out"}, 32'(c_out), 32'(ec));
      chk({tag, "_skip_cnt"}, 32'(skip_cnt), 32'(ek));
      held = s;
      @(posedge clk); #1;
      chk({tag, "_idle_flags"}, 32'({busy, done}), 32'd0);
      chk({tag, "_s_hold"}, 32'(s), 32'(es));
      chk({tag, "_s_hold_prev"}, 32'(s), 32'(held));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [16:0] sum;
    logic [15:0] ra, rb;
    logic        rc;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 3'd0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 3'd4};
    tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3'd3};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 3'd0};
    tbl[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 3'd1};
    tbl[5] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 3'd4};
    tbl[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 3'd4};
    tbl[7] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 3'd4};
    tbl[8] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 3'd2};
    tbl[9] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_s", 32'(s), 32'd0);
    chk("reset_c_out", 32'(c_out), 32'd0);
    chk("reset_skip", 32'(skip_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", 32'({busy, done}), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, tbl[i].sk, 1'b0,
             $sformatf("vec%0d", i));
    end

    // Start pulsed mid-RUN must be ignored.
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 3'd1, 1'b1, "mid_start");

    // Back-to-back with start held high: accepted at the edge after each done cycle.
    a = tbl[0].a; b = tbl[0].b; c_in = tbl[0].cin; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int j;
      j = i + 1;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_accept_busy", i), 32'({busy, done}), 32'b10);
      a = tbl[j].a; b = tbl[j].b; c_in = tbl[j].cin;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        chk($sformatf("b2b%0d_run%0d", i, k), 32'({busy, done}), 32'b10);
      end
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_done", i), 32'({busy, done}), 32'b01);
      chk($sformatf("b2b%0d_s", i), 32'(s), 32'(tbl[i].s));
      chk($sformatf("b2b%0d_c_out", i), 32'(c_out), 32'(tbl[i].co));
      chk($sformatf("b2b%0d_skip", i), 32'(skip_cnt), 32'(tbl[i].sk));
      if (i == 2) start = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b_end_idle", 32'({busy, done}), 32'd0);

    // Reset during the second RUN cycle aborts the op.
    a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({busy, done, c_out, skip_cnt, s}), 32'd0);
    ndone = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 3'd0, 1'b0, "after_abort");

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      sum = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      run_op(ra, rb, rc, sum[15:0], sum[16], mskip(ra, rb), 1'b0, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_seq_ctrl.md
Name: csa_seq_ctrl

Overview:
Sequencing controller that performs a WIDTH-bit addition by iterating a single 4-bit carry-skip adder slice over WIDTH/4 cycles, least-significant nibble first. A registered carry links the slices. Start/busy/done handshake to the requesting logic. The block also counts how many slices took the skip (bypass) path, for datapath profiling. It sits between a wide-operand requester and the shared 4-bit carry-skip slice, which is instantiated inside this block.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
NSLICE (localparam), WIDTH/4, number of slice iterations.
CW (localparam), $clog2(NSLICE+1), width of the slice index and of skip_cnt.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE or DONE.
a  input  WIDTH  operand A; latched on an accepted start.
b  input  WIDTH  operand B; latched on an accepted start.
c_in  input  1  carry in; latched on an accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; s, c_out and skip_cnt are valid from this cycle on.
s  output  WIDTH  sum, registered.
c_out  output  1  final carry, registered.
skip_cnt  output  CW  number of slices whose 4 propagate bits were all 1.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, s, c_out and skip_cnt are 0. Internal operand, carry and index registers are 0.
- Reset asserted mid-RUN aborts the operation. There is no done pulse, and no partial result survives.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at edge k:
  - latch a, b and c_in;
  - carry reg <= c_in, idx <= 0, skip_cnt <= 0, s <= 0, c_out <= 0;
  - state <= RUN.
- IDLE/DONE with start=0: DONE always goes to IDLE; IDLE stays in IDLE.
- RUN, each edge:
  - the slice adds a_l[4*idx+:4], b_l[4*idx+:4] and the carry reg;
  - s[4*idx+:4] <= slice sum; carry reg <= slice carry;
  - skip_cnt increments if p = a_l^b_l over that nibble is 4'b1111;
  - idx increments.
  - When idx == NSLICE-1: c_out <= slice carry, state <= DONE.
- Slice carry rule: if all four propagate bits are 1, slice carry-out = slice carry-in (skip path); otherwise it is the ripple carry out of bit 3. The result must equal the mathematical a+b+c_in, with {c_out,s} WIDTH+1 bits wide.
- Outputs:
  - busy = (state==RUN), decoded from the state register.
  - done = (state==DONE), so it is high exactly one cycle.
- Latency: start accepted at edge k; done is high in the cycle after edge k+NSLICE. For WIDTH=16, that is 4 RUN cycles followed by 1 DONE cycle.
- start during RUN is ignored: no relatch and no effect on the result.
- start in the DONE cycle is accepted. The next op begins immediately; the results then clear at that edge, so the requester must capture them during done.
- s, c_out and skip_cnt hold their values in IDLE until the next accepted start.
- Operand inputs may change freely after acceptance, since only the latched copies are used.

Test Plan:
1. Reset, then a=0x1234, b=0x4321, c_in=0, start pulse → busy high for 4 cycles, done in the 5th cycle after the start edge; s=0x5555, c_out=0, skip_cnt=0.
2. a=0xFFFF, b=0x0000, c_in=1 → s=0x0000, c_out=1, skip_cnt=4 (carry skips every slice).
3. a=0xFFFF, b=0x0001, c_in=0 → s=0x0000, c_out=1, skip_cnt=3. a=0x8000, b=0x8000, c_in=0 → s=0x0000, c_out=1, skip_cnt=0.
4. Start a=0x00FF, b=0x0001, c_in=0, then pulse start with a=0xAAAA, b=0x5555 mid-RUN → result s=0x0100, c_out=0 (second start ignored); busy unaffected.
5. Start held high continuously → ops run back-to-back at a 5-cycle period; each done pulse carries the correct result for operands latched at its accepting edge.
6. Drive rst_n low during the 2nd RUN cycle → all outputs 0 immediately, no done pulse; a fresh op afterwards returns the correct result. Random compare of 1000 vectors against a+b+c_in.
